ex_issue: RTL and testbench
===========================

# ex_issue

Execute-stage issue/complete controller for the processor datapath. It sits between decode and writeback, on the other side of the ALU operand/result interface. It accepts one decoded operation at a time over a valid/ready handshake and computes the ALU function. MUL runs as an iterative shift-add over DSIZE cycles. Each result is returned with its destination tag through a one-entry, back-pressured output register.

## Interface
- DSIZE, default `DSIZE` (16), datapath width
- RSIZE, default 4, destination register tag width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous and active-high
- in_valid  in  1  decode presents an operation
- in_ready  out  1  block accepts the operation this cycle
- in_op  in  3  operation code: `ADD`, `SUB`, `AND`, `XOR`, `SLL`, `SRL`, `COM`, `MUL`
- in_a, in_b  in  DSIZE  operands
- in_imm  in  DSIZE  shift amount for SLL/SRL
- in_rd  in  RSIZE  destination tag
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes the result
- out_result  out  DSIZE  result
- out_zero  out  1  1 when the accepted operands satisfied a == b
- out_rd  out  RSIZE  echoed destination tag
- busy  out  1  FSM not in IDLE

## Operation
- Acceptance: an operation is accepted on an edge where in_valid && in_ready. in_ready = (state == IDLE) && (!out_valid || out_ready). It is combinational and does not depend on in_valid.
- FSM states and transitions:
  - IDLE: accepting a non-MUL op writes the result into the output register and stays in IDLE. Accepting a MUL latches the operands, sets the counter to DSIZE and moves to MUL.
  - MUL: each edge performs one shift-add step, taking the multiplier LSB first, and decrements the counter.
  - Exit from MUL: when the counter reaches 0 and the output slot is free or draining, the result is written to the output register and the FSM returns to IDLE. If out_valid is high and out_ready is low, it holds in MUL with counter 0 until the slot frees.
- Arithmetic: all operations are unsigned, modulo 2^DSIZE.
  - SUB wraps.
  - MUL keeps the low DSIZE bits of the product.
  - COM returns {0…, a <= b}.
  - SLL/SRL shift a by in_imm. Any in_imm >= DSIZE yields 0.
- out_zero = (a == b), evaluated on the operands at acceptance, for every op.
- Output register: out_result, out_zero and out_rd are stable while out_valid && !out_ready. out_valid clears on the edge where out_ready is high, unless a new result is written on that same edge.

## Timing
- Reset values: out_valid 0, out_result 0, out_zero 0, out_rd 0, state IDLE, counter 0. As a result busy = 0 and in_ready = 1 once reset is applied.
- Non-MUL latency is 1: the op is accepted at edge E0 and out_valid is high in the cycle after E0. Throughput is 1 op/cycle when out_ready stays high.
- MUL latency is DSIZE (counting from the acceptance edge E0 to out_valid) when the output is free. in_ready is low for DSIZE cycles.
- Simultaneous drain and accept in the same cycle: the old result leaves and the new result loads on the same edge, with no bubble.
- Reset mid-MUL abandons the operation with no output. The next operation starts cleanly.

## Configuration
- FAST_MUL_EN
  - Defined: MUL completes in 1 cycle with the same timing as the other ops. The MUL state and seq_mul are not built, and busy is always 0.
  - Undefined: the iterative DSIZE-cycle MUL described above.

## Structure
- Shared define file holds DSIZE, the eight op codes and the FSM state encodings (IDLE, MUL).
- One sub-module: seq_mul, an iterative shift-add multiplier with start/done, a counter and operand/accumulator registers. It is instantiated only without FAST_MUL_EN.
- Single-cycle ops are a combinational case inside ex_issue.

## Test plan
- **ADD:** ADD a=0x0003 b=0x0004 rd=2, out_ready=1 -> out_valid the next cycle, out_result 0x0007, out_zero 0, out_rd 2.
- **MUL:** MUL 0x0012 × 0x0034 -> in_ready low 16 cycles, then out_result 0x03A8. MUL 0x0100 × 0x0100 -> 0x0000.
- **Back-pressure:** out_ready=0, SUB a=5 b=7 -> 0xFFFE held stable and in_ready low for 10 cycles; raising out_ready drains it and lets the next op be accepted on the same edge.
- **Streaming:** 8 back-to-back XOR ops with out_ready=1 -> 8 results on 8 consecutive cycles, in order, tags matching.
- **Reset mid-MUL:** assert rst 8 cycles into a MUL -> all outputs 0, busy 0; a following ADD 1+1 returns 0x0002.
- **Shifts and COM:** SLL a=0x0001 imm=15 -> 0x8000; imm=16 -> 0x0000. COM a=5 b=5 -> 0x0001 with out_zero 1.

Source files
------------

// File: rtl/ex_issue_pkg.sv
// Shared definitions for the execute-stage issue controller.
// DSIZE defaults to the `DSIZE macro (16 when not set by the build).
// Optional feature macro: FAST_MUL_EN (single-cycle MUL, no iterative multiplier).
`ifndef DSIZE
`define DSIZE 16
`endif

package ex_issue_pkg;

   localparam int DSIZE_DEF = `DSIZE;
   localparam int RSIZE_DEF = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_XOR = 3'd3,
      OP_SLL = 3'd4,
      OP_SRL = 3'd5,
      OP_COM = 3'd6,
      OP_MUL = 3'd7
   } op_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/ex_issue_if.sv
// Decode-side issue handshake and writeback-side result handshake of ex_issue.
// slave: the execute stage; master: decode/writeback (or a testbench).
interface ex_issue_if #(
   parameter int DSIZE = ex_issue_pkg::DSIZE_DEF,
   parameter int RSIZE = ex_issue_pkg::RSIZE_DEF
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [DSIZE-1:0] in_a;
   logic [DSIZE-1:0] in_b;
   logic [DSIZE-1:0] in_imm;
   logic [RSIZE-1:0] in_rd;
   logic             out_valid;
   logic             out_ready;
   logic [DSIZE-1:0] out_result;
   logic             out_zero;
   logic [RSIZE-1:0] out_rd;
   logic             busy;

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_imm, in_rd, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_rd, busy
   );

   modport master (
      output in_valid, in_op, in_a, in_b, in_imm, in_rd, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_rd, busy
   );
endinterface

// File: rtl/ex_issue_seq_mul.sv
// seq_mul: iterative shift-add multiplier, one multiplier bit per clock, LSB first.
// start loads operands and sets the counter to DSIZE; each following edge with a
// non-zero counter performs one step. product is the accumulator value after the
// step in progress, so the final step's result is usable on the edge it happens.
module seq_mul #(
   parameter int DSIZE = ex_issue_pkg::DSIZE_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DSIZE-1:0] a,
   input  logic [DSIZE-1:0] b,
   output logic             done,
   output logic [DSIZE-1:0] product
);
   localparam int CW = $clog2(DSIZE + 1);

   logic [DSIZE-1:0] mcand;
   logic [DSIZE-1:0] mplier;
   logic [DSIZE-1:0] acc;
   logic [DSIZE-1:0] acc_next;
   logic [CW-1:0]    cnt;

   // Partial-product add for the current step (nothing once the counter is spent)
   always_comb begin
      acc_next = acc;
      if (cnt != '0 && mplier[0])
         acc_next = acc + mcand;
   end

   // Operand load on start, otherwise one shift-add step per edge until done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         cnt    <= CW'(DSIZE);
      end else if (cnt != '0) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
      end
   end

   assign done    = (cnt <= CW'(1));
   assign product = acc_next;

endmodule

// File: rtl/ex_issue.sv
// ex_issue: execute-stage issue/complete controller. Accepts one decoded op per
// handshake, computes single-cycle ALU ops combinationally and MUL either
// iteratively (seq_mul) or in one cycle when FAST_MUL_EN is defined. Results
// leave through a one-entry back-pressured output register.
module ex_issue
   import ex_issue_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF,
   parameter int RSIZE = RSIZE_DEF
) (
   input  logic       clk,
   input  logic       rst,
   ex_issue_if.slave  bus
);
   localparam logic [DSIZE-1:0] SHIFT_LIMIT = DSIZE'(DSIZE);

   op_t              op;
   logic             slot_free;
   logic             accept;
   logic             operands_equal;
   logic [DSIZE-1:0] alu_result;
   logic             load;
   logic [DSIZE-1:0] load_result;
   logic             load_zero;
   logic [RSIZE-1:0] load_rd;

   assign op             = op_t'(bus.in_op);
   assign slot_free      = !bus.out_valid || bus.out_ready;
   assign accept         = bus.in_valid && bus.in_ready;
   assign operands_equal = (bus.in_a == bus.in_b);

   // Single-cycle ALU result for the op currently presented
   always_comb begin
      alu_result = '0;
      case (op)
         OP_ADD: alu_result = bus.in_a + bus.in_b;
         OP_SUB: alu_result = bus.in_a - bus.in_b;
         OP_AND: alu_result = bus.in_a & bus.in_b;
         OP_XOR: alu_result = bus.in_a ^ bus.in_b;
         OP_SLL: alu_result = (bus.in_imm >= SHIFT_LIMIT) ? '0 : (bus.in_a << bus.in_imm);
         OP_SRL: alu_result = (bus.in_imm >= SHIFT_LIMIT) ? '0 : (bus.in_a >> bus.in_imm);
         OP_COM: alu_result = {{(DSIZE-1){1'b0}}, (bus.in_a <= bus.in_b)};
`ifdef FAST_MUL_EN
         OP_MUL: alu_result = bus.in_a * bus.in_b;
`else
         OP_MUL: alu_result = '0;
`endif
         default: alu_result = '0;
      endcase
   end

`ifdef FAST_MUL_EN

   assign bus.in_ready = slot_free;
   assign bus.busy     = 1'b0;
   assign load         = accept;
   assign load_result  = alu_result;
   assign load_zero    = operands_equal;
   assign load_rd      = bus.in_rd;

`else

   state_t           state;
   state_t           state_n;
   logic             mul_start;
   logic             mul_done;
   logic [DSIZE-1:0] mul_product;
   logic             pend_zero;
   logic [RSIZE-1:0] pend_rd;

   assign bus.in_ready = (state == S_IDLE) && slot_free;
   assign bus.busy     = (state != S_IDLE);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   // Tag and equality flag of an in-flight MUL, captured at acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_zero <= 1'b0;
         pend_rd   <= '0;
      end else if (mul_start) begin
         pend_zero <= operands_equal;
         pend_rd   <= bus.in_rd;
      end
   end

   // Next state and output-register load selection
   always_comb begin
      state_n     = state;
      mul_start   = 1'b0;
      load        = 1'b0;
      load_result = alu_result;
      load_zero   = operands_equal;
      load_rd     = bus.in_rd;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (op == OP_MUL) begin
                  mul_start = 1'b1;
                  state_n   = S_MUL;
               end else begin
                  load = 1'b1;
               end
            end
         end
         S_MUL: begin
            // Final step and write-back share an edge; if the slot is blocked
            // the counter parks at 0 and the product is held until it frees.
            if (mul_done && slot_free) begin
               load        = 1'b1;
               load_result = mul_product;
               load_zero   = pend_zero;
               load_rd     = pend_rd;
               state_n     = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   seq_mul #(.DSIZE(DSIZE)) u_seq_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (bus.in_a),
      .b       (bus.in_b),
      .done    (mul_done),
      .product (mul_product)
   );

`endif

   // One-entry output register: load wins over drain on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.out_result <= '0;
         bus.out_zero   <= 1'b0;
         bus.out_rd     <= '0;
      end else if (load) begin
         bus.out_valid  <= 1'b1;
         bus.out_result <= load_result;
         bus.out_zero   <= load_zero;
         bus.out_rd     <= load_rd;
      end else if (bus.out_ready) begin
         bus.out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_issue.sv
// Testbench for ex_issue: directed cases with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_ex_issue;
   import ex_issue_pkg::*;

   localparam int DW = 16;
   localparam int RW = 4;
`ifdef FAST_MUL_EN
   localparam bit MUL_SEQ = 1'b0;
`else
   localparam bit MUL_SEQ = 1'b1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic check_en = 1'b0;
   int   total = 0;
   int   bad = 0;

   ex_issue_if #(.DSIZE(DW), .RSIZE(RW)) bus();

   ex_issue #(.DSIZE(DW), .RSIZE(RW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic from the op definitions, in wide integers
   function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic [DW-1:0] imm);
      longint unsigned x;
      longint unsigned m;
      m = longint'(1) << DW;
      case (op)
         OP_ADD:  x = longint'(a) + longint'(b);
         OP_SUB:  x = longint'(a) + m - longint'(b);
         OP_AND:  x = longint'(a & b);
         OP_XOR:  x = longint'(a ^ b);
         OP_SLL:  x = (imm >= DW) ? 0 : longint'(a) * (longint'(1) << imm);
         OP_SRL:  x = (imm >= DW) ? 0 : longint'(a) / (longint'(1) << imm);
         OP_COM:  x = (a <= b) ? 1 : 0;
         default: x = longint'(a) * longint'(b);
      endcase
      x = x % m;
      return x[DW-1:0];
   endfunction

   // Behavioural model: output slot contents plus the edge a pending MUL is due
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_res = '0;
   logic          m_zero = 1'b0;
   logic [RW-1:0] m_rd = '0;
   logic          m_busy = 1'b0;
   longint        cyc = 0;
   longint        mul_due = 0;
   logic [DW-1:0] p_res = '0;
   logic          p_zero = 1'b0;
   logic [RW-1:0] p_rd = '0;

   initial forever begin : model
      logic          free;
      logic          acc;
      logic          wr;
      logic [DW-1:0] wres;
      logic          wz;
      logic [RW-1:0] wrd;
      @(posedge clk or posedge rst);
      if (rst) begin
         m_valid = 1'b0; m_res = '0; m_zero = 1'b0; m_rd = '0;
         m_busy = 1'b0; cyc = 0;
      end else begin
         cyc++;
         free = !m_valid || bus.out_ready;
         acc  = bus.in_valid && !m_busy && free;
         wr   = 1'b0; wres = '0; wz = 1'b0; wrd = '0;
         if (m_busy) begin
            if (cyc >= mul_due && free) begin
               wr = 1'b1; wres = p_res; wz = p_zero; wrd = p_rd;
               m_busy = 1'b0;
            end
         end else if (acc) begin
            if (bus.in_op == OP_MUL && MUL_SEQ) begin
               m_busy  = 1'b1;
               mul_due = cyc + DW;
               p_res   = ref_alu(bus.in_op, bus.in_a, bus.in_b, bus.in_imm);
               p_zero  = (bus.in_a == bus.in_b);
               p_rd    = bus.in_rd;
            end else begin
               wr = 1'b1;
               wres = ref_alu(bus.in_op, bus.in_a, bus.in_b, bus.in_imm);
               wz = (bus.in_a == bus.in_b);
               wrd = bus.in_rd;
            end
         end
         if (wr) begin
            m_valid = 1'b1; m_res = wres; m_zero = wz; m_rd = wrd;
         end else if (bus.out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   // Every-cycle comparison of the DUT against the model, mid-cycle
   initial forever begin
      @(negedge clk);
      if (!rst && check_en) begin
         check("m_in_ready", 32'(bus.in_ready), 32'(!m_busy && (!m_valid || bus.out_ready)));
         check("m_busy", 32'(bus.busy), 32'(m_busy));
         check("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
         if (m_valid) begin
            check("m_out_result", 32'(bus.out_result), 32'(m_res));
            check("m_out_zero", 32'(bus.out_zero), 32'(m_zero));
            check("m_out_rd", 32'(bus.out_rd), 32'(m_rd));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   task automatic set_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] imm, input logic [RW-1:0] rd);
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
      bus.in_imm = imm; bus.in_rd = rd;
   endtask

   // Present an op and hold it until accepted; returns at 1 time unit past the accept edge
   task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] imm, input logic [RW-1:0] rd, output int waits);
      waits = 0;
      set_op(op, a, b, imm, rd);
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         waits++;
         if (waits > 100) begin
            check("issue_accept_timeout", 32'(waits), 32'(0));
            break;
         end
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   // Literal check of the output register at the current sample point
   task automatic check_out(input string name, input logic [DW-1:0] res, input logic z, input logic [RW-1:0] rd);
      check({name, "_valid"}, 32'(bus.out_valid), 32'(1));
      check({name, "_result"}, 32'(bus.out_result), 32'(res));
      check({name, "_zero"}, 32'(bus.out_zero), 32'(z));
      check({name, "_rd"}, 32'(bus.out_rd), 32'(rd));
   endtask

   initial begin
      int            w;
      int            n;
      int            held;
      logic [DW-1:0] xa;
      bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
      bus.in_imm = '0; bus.in_rd = '0; bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_out_result", 32'(bus.out_result), 32'(0));
      check("rst_out_zero", 32'(bus.out_zero), 32'(0));
      check("rst_out_rd", 32'(bus.out_rd), 32'(0));
      check("rst_busy", 32'(bus.busy), 32'(0));
      check("rst_in_ready", 32'(bus.in_ready), 32'(1));
      rst = 1'b0;
      check_en = 1'b1;

      // ADD, latency 1
      issue(OP_ADD, 16'h0003, 16'h0004, 16'h0, 4'd2, w);
      @(negedge clk);
      check_out("add", 16'h0007, 1'b0, 4'd2);
      @(posedge clk); #1;

      // MUL 0x12 * 0x34
      issue(OP_MUL, 16'h0012, 16'h0034, 16'h0, 4'd6, w);
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready || n >= 100) break;
         n++;
      end
      check("mul_ready_low_cycles", 32'(n), MUL_SEQ ? 32'(DW) : 32'(0));
      check_out("mul1", 16'h03A8, 1'b0, 4'd6);
      @(posedge clk); #1;

      // MUL wrapping to zero, equal operands
      issue(OP_MUL, 16'h0100, 16'h0100, 16'h0, 4'd7, w);
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.out_valid || n >= 100) break;
         n++;
      end
      check_out("mul2", 16'h0000, 1'b1, 4'd7);
      @(posedge clk); #1;

      // Back-pressure: held result, then drain + accept on one edge
      bus.out_ready = 1'b0;
      issue(OP_SUB, 16'd5, 16'd7, 16'h0, 4'd3, w);
      held = 0;
      repeat (10) begin
         @(negedge clk);
         if (!bus.in_ready && bus.out_valid && bus.out_result == 16'hFFFE && bus.out_rd == 4'd3) held++;
      end
      check("bp_held_cycles", 32'(held), 32'(10));
      check_out("bp_sub", 16'hFFFE, 1'b0, 4'd3);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      issue(OP_ADD, 16'h0003, 16'h0004, 16'h0, 4'd5, w);
      check("bp_same_edge_waits", 32'(w), 32'(0));
      @(negedge clk);
      check_out("bp_next", 16'h0007, 1'b0, 4'd5);
      @(posedge clk); #1;

      // Streaming: 8 back-to-back XORs
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) set_op(OP_XOR, 16'(i * 16'h0111), 16'h0F0F, 16'h0, 4'(i));
         else bus.in_valid = 1'b0;
         @(negedge clk);
         if (i < 8) check("stream_in_ready", 32'(bus.in_ready), 32'(1));
         if (i > 0) begin
            xa = 16'((i - 1) * 16'h0111);
            check_out("stream", xa ^ 16'h0F0F, 1'b0, 4'(i - 1));
         end
         @(posedge clk); #1;
      end

      // Shifts and COM
      issue(OP_SLL, 16'h0001, 16'h0000, 16'd15, 4'd1, w);
      @(negedge clk);
      check_out("sll15", 16'h8000, 1'b0, 4'd1);
      @(posedge clk); #1;
      issue(OP_SLL, 16'h0001, 16'h0000, 16'd16, 4'd2, w);
      @(negedge clk);
      check_out("sll16", 16'h0000, 1'b0, 4'd2);
      @(posedge clk); #1;
      issue(OP_SRL, 16'h8000, 16'h0001, 16'd15, 4'd3, w);
      @(negedge clk);
      check_out("srl15", 16'h0001, 1'b0, 4'd3);
      @(posedge clk); #1;
      issue(OP_COM, 16'd5, 16'd5, 16'h0, 4'd4, w);
      @(negedge clk);
      check_out("com_eq", 16'h0001, 1'b1, 4'd4);
      @(posedge clk); #1;

      // Reset in the middle of a MUL
      issue(OP_MUL, 16'h1234, 16'h0005, 16'h0, 4'd9, w);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
      check("midrst_out_result", 32'(bus.out_result), 32'(0));
      check("midrst_out_zero", 32'(bus.out_zero), 32'(0));
      check("midrst_out_rd", 32'(bus.out_rd), 32'(0));
      check("midrst_busy", 32'(bus.busy), 32'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      issue(OP_ADD, 16'h0001, 16'h0001, 16'h0, 4'd1, w);
      @(negedge clk);
      check_out("post_rst_add", 16'h0002, 1'b1, 4'd1);
      @(posedge clk); #1;

      // Randomized traffic checked by the model
      repeat (800) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_op     = 3'($urandom_range(0, 7));
         bus.in_a      = 16'($urandom);
         bus.in_b      = ($urandom_range(0, 3) == 0) ? bus.in_a : 16'($urandom);
         bus.in_imm    = 16'($urandom_range(0, 20));
         bus.in_rd     = 4'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (24) @(posedge clk);
      #1;
      check("final_idle_out_valid", 32'(bus.out_valid), 32'(0));
      check("final_idle_busy", 32'(bus.busy), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
